// File: rtl/servo_pwm_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM.
// Register offsets, STATUS bit layout and the width clamp.
package servo_pwm_pkg;

  localparam logic [4:0] REG_CTRL       = 5'd0;
  localparam logic [4:0] REG_STATUS     = 5'd1;
  localparam logic [4:0] REG_WIDTH_BASE = 5'd2;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_CNT_LSB  = 16;
  localparam int STATUS_CNT_W    = 16;

  function automatic logic [15:0] clamp_us(
    input logic [15:0] v,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: clamped shadow width, frame-latched active
// width and enable, compare and registered output.
// Ports: clk, reset, i_frame_start, i_frame_cnt_nxt, i_en_shadow,
//        i_wr, i_wdata, o_shadow (readback), o_pwm.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int FW        = 15,
  parameter int MIN_US    = 500,
  parameter int MAX_US    = 2500,
  parameter int CENTER_US = 1500
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_frame_start,
  input  logic [FW-1:0] i_frame_cnt_nxt,
  input  logic          i_en_shadow,
  input  logic          i_wr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_shadow,
  output logic          o_pwm
);

  localparam logic [15:0]   LO    = 16'(MIN_US);
  localparam logic [15:0]   HI    = 16'(MAX_US);
  localparam logic [FW-1:0] RST_W = FW'(CENTER_US);

  logic [FW-1:0] r_shadow;
  logic [FW-1:0] r_active;
  logic          r_en;
  logic          r_pwm;

  logic [FW-1:0] w_active_nxt;
  logic          w_en_nxt;

  // Active copies only move at frame_start and see the pre-write shadow.
  assign w_en_nxt     = i_frame_start ? i_en_shadow : r_en;
  assign w_active_nxt = i_frame_start ? r_shadow : r_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= RST_W;
      r_active <= RST_W;
      r_en     <= 1'b0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_wr)
        r_shadow <= FW'(clamp_us(i_wdata, LO, HI));
      r_active <= w_active_nxt;
      r_en     <= w_en_nxt;
      // Compare on next-state values so the output lines up with
      // frame_cnt and rises the cycle after frame_start.
      r_pwm    <= w_en_nxt && (i_frame_cnt_nxt < w_active_nxt);
    end
  end

  assign o_shadow = 16'(r_shadow);
  assign o_pwm    = r_pwm;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM with Avalon-MM slave and shared timebase.
// Ports: clk, reset, avs_* (5-bit word address, 1-cycle read), pwm_out.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int TICK_DIV  = 50,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 500,
  parameter int MAX_US    = 2500,
  parameter int CENTER_US = 1500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int FW = $clog2(PERIOD_US);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_US - 1);

  logic [PW-1:0]           r_presc;
  logic [FW-1:0]           r_frame_cnt;
  logic [NUM_CH-1:0]       r_ctrl;
  logic                    r_done;
  logic [STATUS_CNT_W-1:0] r_fcount;
  logic [31:0]             r_rdata;

  logic              w_us_tick;
  logic              w_frame_start;
  logic [FW-1:0]     w_frame_cnt_nxt;
  logic              w_wr_ctrl;
  logic              w_wr_status;
  logic [NUM_CH-1:0] w_wr_width;
  logic [15:0]       w_shadow [NUM_CH];
  logic [NUM_CH-1:0] w_pwm;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_unused      = ^avs_writedata;
  assign w_us_tick     = (r_presc == PRESC_LAST);
  assign w_frame_start = w_us_tick && (r_frame_cnt == FRAME_LAST);
  assign w_wr_ctrl     = avs_write && (avs_address == REG_CTRL);
  assign w_wr_status   = avs_write && (avs_address == REG_STATUS);

  always_comb begin
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_frame_start)
      w_frame_cnt_nxt = '0;
    else if (w_us_tick)
      w_frame_cnt_nxt = r_frame_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_presc     <= w_us_tick ? '0 : r_presc + 1'b1;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl   <= '0;
      r_done   <= 1'b0;
      r_fcount <= '0;
    end else begin
      if (w_wr_ctrl)
        r_ctrl <= avs_writedata[NUM_CH-1:0];
      // A set on frame_start beats a same-cycle W1C.
      if (w_frame_start)
        r_done <= 1'b1;
      else if (w_wr_status && avs_writedata[STATUS_DONE_BIT])
        r_done <= 1'b0;
      if (w_frame_start)
        r_fcount <= r_fcount + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr_width[i] = avs_write &&
      (avs_address == 5'(REG_WIDTH_BASE + 5'(i)));

    servo_pwm_channel #(
      .FW        (FW),
      .MIN_US    (MIN_US),
      .MAX_US    (MAX_US),
      .CENTER_US (CENTER_US)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .i_frame_start   (w_frame_start),
      .i_frame_cnt_nxt (w_frame_cnt_nxt),
      .i_en_shadow     (r_ctrl[i]),
      .i_wr            (w_wr_width[i]),
      .i_wdata         (avs_writedata[15:0]),
      .o_shadow        (w_shadow[i]),
      .o_pwm           (w_pwm[i])
    );
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (avs_address == REG_CTRL):
        w_rdata = 32'(r_ctrl);
      (avs_address == REG_STATUS): begin
        w_rdata[STATUS_DONE_BIT] = r_done;
        w_rdata[STATUS_CNT_LSB +: STATUS_CNT_W] = r_fcount;
      end
      default:
        for (int i = 0; i < NUM_CH; i++)
          if (avs_address == 5'(REG_WIDTH_BASE + 5'(i)))
            w_rdata = 32'(w_shadow[i]);
    endcase
  end

  // Registers are sampled before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (reset)
      r_rdata <= '0;
    else if (avs_read)
      r_rdata <= w_rdata;
  end

  assign avs_readdata = r_rdata;
  assign pwm_out      = w_pwm;

endmodule
